// File: rtl/matvec_row_sequencer.sv
// Matrix-vector sequencer: issues one row at a time to an external inner-product unit and
// collects each scalar result into a packed result vector, handshaking it out with valid/ready.
module matvec_row_sequencer #(
  parameter int data_width = 2,
  parameter int num_elems  = 2,
  parameter int num_rows   = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [num_rows*num_elems*data_width-1:0] mat_in,
  input  logic [num_elems*data_width-1:0]          vec_in,
  output logic                                     busy,
  output logic [num_elems*data_width-1:0]          ip_row,
  output logic [num_elems*data_width-1:0]          ip_vec,
  output logic                                     ip_valid,
  input  logic [data_width-1:0]                    ip_result,
  input  logic                                     ip_result_valid,
  output logic [num_rows*data_width-1:0]           res_out,
  output logic                                     res_valid,
  input  logic                                     res_ready
);

  localparam int R  = num_elems * data_width;
  localparam int MW = num_rows * R;
  localparam int OW = num_rows * data_width;
  localparam int RW = (num_rows > 1) ? $clog2(num_rows) : 1;
  localparam logic [RW-1:0] LAST = RW'(num_rows - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   r_q, r_d;
  logic [MW-1:0]   mat_q, mat_d;
  logic [R-1:0]    vec_q, vec_d;
  logic [R-1:0]    ip_row_q, ip_row_d;
  logic [R-1:0]    ip_vec_q, ip_vec_d;
  logic            ip_valid_q, ip_valid_d;
  logic            res_valid_q, res_valid_d;
  logic [OW-1:0]   res_q, res_d;

  function automatic logic [R-1:0] row_sel(input logic [MW-1:0] m, input logic [RW-1:0] idx);
    row_sel = '0;
    for (int i = 0; i < num_rows; i++) begin
      if (idx == RW'(i)) row_sel = m[i*R +: R];
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    mat_d       = mat_q;
    vec_d       = vec_q;
    ip_row_d    = ip_row_q;
    ip_vec_d    = ip_vec_q;
    ip_valid_d  = 1'b0;
    res_valid_d = 1'b0;
    res_d       = res_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mat_d      = mat_in;
          vec_d      = vec_in;
          r_d        = '0;
          ip_row_d   = mat_in[R-1:0];
          ip_vec_d   = vec_in;
          ip_valid_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (ip_result_valid) begin
          for (int i = 0; i < num_rows; i++) begin
            if (r_q == RW'(i)) res_d[i*data_width +: data_width] = ip_result;
          end
          if (r_q == LAST) begin
            res_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            // Next row is loaded here so it is already stable when its strobe rises.
            r_d        = r_q + RW'(1);
            ip_row_d   = row_sel(mat_q, r_q + RW'(1));
            ip_valid_d = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      mat_q       <= '0;
      vec_q       <= '0;
      ip_row_q    <= '0;
      ip_vec_q    <= '0;
      ip_valid_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      mat_q       <= mat_d;
      vec_q       <= vec_d;
      ip_row_q    <= ip_row_d;
      ip_vec_q    <= ip_vec_d;
      ip_valid_q  <= ip_valid_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign ip_row    = ip_row_q;
  assign ip_vec    = ip_vec_q;
  assign ip_valid  = ip_valid_q;
  assign res_out   = res_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_matvec_row_sequencer.sv
// Randomized bench for matvec_row_sequencer with a latency-programmable inner-product responder
// and a sum-of-products reference model.
module tb_matvec_row_sequencer;

  localparam int DW = 2;
  localparam int NE = 2;
  localparam int NR = 2;
  localparam int R  = DW * NE;
  localparam int MW = NR * R;
  localparam int OW = NR * DW;

  logic          clk = 1'b0;
  logic          rst, start, ip_result_valid, res_ready;
  logic [MW-1:0] mat_in;
  logic [R-1:0]  vec_in;
  logic [DW-1:0] ip_result;
  logic          busy, ip_valid, res_valid;
  logic [R-1:0]  ip_row, ip_vec;
  logic [OW-1:0] res_out;

  matvec_row_sequencer #(.data_width(DW), .num_elems(NE), .num_rows(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .mat_in(mat_in), .vec_in(vec_in),
    .busy(busy), .ip_row(ip_row), .ip_vec(ip_vec), .ip_valid(ip_valid),
    .ip_result(ip_result), .ip_result_valid(ip_result_valid),
    .res_out(res_out), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inner product of two packed vectors, modulo 2^DW.
  function automatic int model(input logic [R-1:0] a, input logic [R-1:0] b);
    int s = 0;
    for (int e = 0; e < NE; e++) s += int'(a[e*DW +: DW]) * int'(b[e*DW +: DW]);
    return s % (1 << DW);
  endfunction

  int            cyc = 0;
  bit            pend = 0;
  int            due = 0;
  logic [DW-1:0] pend_val;
  int            lat = 1;
  bit            mute = 0;
  bit            spur = 0;

  // One clock: responder drives its result L cycles after seeing ip_valid.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    ip_result_valid = 1'b0;
    if (pend && cyc == due) begin
      ip_result_valid = 1'b1;
      ip_result       = pend_val;
      pend            = 0;
    end else if (spur) begin
      ip_result_valid = 1'b1;
      ip_result       = DW'($urandom);
      spur            = 0;
    end
    if (ip_valid && !mute) begin
      pend     = 1;
      due      = cyc + lat;
      pend_val = DW'(model(ip_row, ip_vec));
    end
  endtask

  task automatic run_op(input logic [MW-1:0] m, input logic [R-1:0] v, input int L,
                        input int hold, input bit busy_start);
    logic [OW-1:0] exp_res;
    int k, npulse;
    bit poked;
    lat = L;
    for (int r = 0; r < NR; r++) exp_res[r*DW +: DW] = DW'(model(m[r*R +: R], v));
    mat_in = m;
    vec_in = v;
    start  = 1'b1;
    step();
    start  = 1'b0;
    k      = 1;
    npulse = 0;
    poked  = 0;
    while (!res_valid && k < 200) begin
      if (ip_valid) begin
        if (npulse < NR) check("ip_row", ip_row, m[npulse*R +: R]);
        check("ip_vec", ip_vec, v);
        npulse++;
      end else if (busy_start && !poked && npulse == 1) begin
        mat_in = ~m;
        vec_in = ~v;
        start  = 1'b1;
        poked  = 1;
      end
      step();
      start = 1'b0;
      k++;
    end
    check("res_valid_latency", k, NR * (L + 1) + 1);
    check("ip_valid_pulses", npulse, NR);
    check("res_out_done", res_out, exp_res);
    check("busy_done", busy, 1);
    for (int h = 0; h < hold; h++) begin
      spur = 1;
      step();
      check("hold_res_valid", res_valid, 1);
      check("hold_res_out", res_out, exp_res);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("release_res_valid", res_valid, 0);
    check("release_busy", busy, 0);
    check("release_ip_valid", ip_valid, 0);
    check("idle_res_out", res_out, exp_res);
  endtask

  initial begin
    logic [MW-1:0] m0;
    logic [R-1:0]  v0;
    logic [OW-1:0] basic_exp;
    m0        = 8'b0110_0101;   // row0=[1,1], row1=[2,1]
    v0        = 4'b1001;        // [1,2]
    basic_exp = 4'b0011;        // slot0=3, slot1=0

    rst = 1'b1; start = 1'b0; ip_result_valid = 1'b0; ip_result = '0;
    res_ready = 1'b0; mat_in = '0; vec_in = '0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_ip_valid", ip_valid, 0);
    check("rst_ip_row", ip_row, 0);
    check("rst_ip_vec", ip_vec, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_out", res_out, 0);
    rst = 1'b0;
    step();

    run_op(m0, v0, 1, 0, 0);
    check("basic_res_out", res_out, basic_exp);

    run_op(m0, v0, 1, 5, 0);

    run_op(m0, v0, 1, 0, 1);
    check("busy_start_res_out", res_out, basic_exp);

    spur = 1;
    step();
    check("idle_spurious_res_out", res_out, basic_exp);
    check("idle_spurious_busy", busy, 0);
    run_op(m0, v0, 3, 0, 0);
    check("lat3_res_out", res_out, basic_exp);

    // Abandon an operation while it waits on the inner-product unit.
    mute   = 1;
    mat_in = 8'hff;
    vec_in = 4'hf;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    step();
    check("wait_busy", busy, 1);
    rst = 1'b1;
    step();
    rst  = 1'b0;
    spur = 1;
    step();
    step();
    check("midrst_busy", busy, 0);
    check("midrst_ip_valid", ip_valid, 0);
    check("midrst_ip_row", ip_row, 0);
    check("midrst_ip_vec", ip_vec, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_res_out", res_out, 0);
    mute = 0;
    pend = 0;

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        spur = 1;
        step();
      end
      run_op(MW'($urandom), R'($urandom), $urandom_range(1, 4), $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/matvec_row_sequencer.md
MATVEC_ROW_SEQUENCER -- requirements
Module: matvec_row_sequencer

Interface
REQ-001 SHALL have parameter data_width, default 2, element and result width in bits.
REQ-002 SHALL have parameter num_elems, default 2, elements per row and per vector.
REQ-003 SHALL have parameter num_rows, default 2, matrix rows.
REQ-004 SHALL define R = num_elems*data_width; element e of any packed row or vector SHALL occupy bits [(e+1)*data_width-1 : e*data_width].
REQ-005 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port: start  input  1  request to begin one matrix-vector product.
REQ-008 SHALL have port: mat_in  input  num_rows*R  packed matrix, row r at bits [(r+1)*R-1 : r*R].
REQ-009 SHALL have port: vec_in  input  R  packed vector.
REQ-010 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port: ip_row  output  R  row issued to the downstream inner-product unit.
REQ-012 SHALL have port: ip_vec  output  R  vector issued to the inner-product unit.
REQ-013 SHALL have port: ip_valid  output  1  one-cycle issue strobe.
REQ-014 SHALL have port: ip_result  input  data_width  inner-product result.
REQ-015 SHALL have port: ip_result_valid  input  1  result strobe from the inner-product unit.
REQ-016 SHALL have port: res_out  output  num_rows*data_width  result vector, slot r at bits [(r+1)*data_width-1 : r*data_width].
REQ-017 SHALL have port: res_valid  output  1  result vector available.
REQ-018 SHALL have port: res_ready  input  1  consumer accepts result.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, DONE and a row index r of width max(1, ceil(log2(num_rows))).
REQ-020 In IDLE, start=1 SHALL register mat_in and vec_in, set r=0, and enter ISSUE on the next cycle; start outside IDLE SHALL be ignored.
REQ-021 In ISSUE, the block SHALL assert ip_valid for exactly one cycle with ip_row = captured row r and ip_vec = captured vector, then enter WAIT.
REQ-022 ip_row and ip_vec SHALL remain stable from ISSUE until the matching ip_result_valid.
REQ-023 In WAIT, ip_result_valid=1 SHALL write ip_result into res_out slot r; if r = num_rows-1, enter DONE, otherwise increment r and enter ISSUE.
REQ-024 ip_result_valid SHALL be ignored in IDLE, ISSUE and DONE.
REQ-025 Downstream result latency SHALL be unbounded; WAIT SHALL persist until ip_result_valid.
REQ-026 In DONE, res_valid SHALL be 1 and res_out SHALL be held stable; res_valid and res_out are registered outputs.
REQ-027 In DONE with res_ready=1, the block SHALL return to IDLE on the next cycle, and res_valid SHALL deassert on that cycle.
REQ-028 res_out SHALL hold the last completed result vector in IDLE; slots not yet written in the current operation SHALL hold their previous values.
REQ-029 ip_result SHALL be stored unmodified (no widening, no saturation).
REQ-030 With a downstream latency of L cycles from ip_valid to ip_result_valid, res_valid SHALL rise num_rows*(L+1)+1 cycles after the cycle in which start is accepted.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, r=0, busy=0, ip_valid=0, ip_row=0, ip_vec=0, res_valid=0, res_out=0 and clear the captured matrix and vector, regardless of the current state.
REQ-032 A reset during WAIT SHALL abandon the operation; any ip_result_valid arriving after reset SHALL be ignored.

Verification
REQ-033 The bench SHALL model the inner-product unit as a sum of products modulo 2^data_width with latency L=1, using default parameters.
REQ-034 Basic: mat rows [1,1],[2,1], vec [1,2], start pulse -> two ip_valid pulses; res_valid after 5 cycles; res_out slot0=3, slot1=0.
REQ-035 Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_valid stays 1 and res_out stays constant; after res_ready=1, IDLE and busy=0 on the next cycle.
REQ-036 Start while busy: pulse start with different mat_in during WAIT -> ignored; results match the first operand set.
REQ-037 Reset mid-operation: assert rst during WAIT, then send a late ip_result_valid -> all outputs 0, state IDLE, res_out unchanged at 0.
REQ-038 Latency and spurious strobes: use model latency L=3 and an extra ip_result_valid pulse in IDLE -> same results as REQ-034; res_valid after 9 cycles; the spurious pulse has no effect.
